// File: rtl/avl_skid_slicer.sv
// Avalon-MM pipeline bridge: registered command path through a 2-entry skid buffer,
// read-beat credit throttling and a configurable register chain on the read response.
module avl_skid_slicer #(
  parameter int ADDR_WIDTH  = 27,
  parameter int DATA_WIDTH  = 576,
  parameter int BURST_WIDTH = 7,
  parameter int RSP_STAGES  = 1,
  parameter int MAX_PENDING = 128
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_WIDTH-1:0]     s0_address,
  input  logic                      s0_read,
  input  logic                      s0_write,
  input  logic [DATA_WIDTH-1:0]     s0_writedata,
  input  logic [DATA_WIDTH/8-1:0]   s0_be,
  input  logic [BURST_WIDTH-1:0]    s0_burstcount,
  output logic                      s0_waitrequest,
  output logic [DATA_WIDTH-1:0]     s0_readdata,
  output logic                      s0_readdatavalid,
  output logic [ADDR_WIDTH-1:0]     m0_address,
  output logic                      m0_read,
  output logic                      m0_write,
  output logic [DATA_WIDTH-1:0]     m0_writedata,
  output logic [DATA_WIDTH/8-1:0]   m0_be,
  output logic [BURST_WIDTH-1:0]    m0_burstcount,
  input  logic                      m0_waitrequest,
  input  logic [DATA_WIDTH-1:0]     m0_readdata,
  input  logic                      m0_readdatavalid
);

  localparam int BE_W   = DATA_WIDTH / 8;
  localparam int PEND_W = $clog2(MAX_PENDING + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  address;
    logic                   read;
    logic                   write;
    logic [DATA_WIDTH-1:0]  writedata;
    logic [BE_W-1:0]        be;
    logic [BURST_WIDTH-1:0] burstcount;
  } cmd_t;

  cmd_t              s0_cmd;
  cmd_t              main_p0;
  cmd_t              skid_p0;
  logic              main_valid;
  logic              skid_valid;
  logic [PEND_W-1:0] pending;
  logic [PEND_W:0]   pend_sum;
  logic              throttle;
  logic              fire;
  logic              read_fire;
  logic              main_free;
  logic              accept;

  // Outstanding-beat count after this cycle's issue and return.
  function automatic logic [PEND_W-1:0] pending_next(
    input logic [PEND_W-1:0]      cur,
    input logic                   issue,
    input logic [BURST_WIDTH-1:0] beats,
    input logic                   ret
  );
    logic [PEND_W-1:0] add;
    logic [PEND_W-1:0] sub;
    add = issue ? PEND_W'(beats) : '0;
    sub = ret ? PEND_W'(1) : '0;
    return cur + add - sub;
  endfunction

  assign s0_cmd = {s0_address, s0_read, s0_write, s0_writedata, s0_be, s0_burstcount};

  assign pend_sum  = {1'b0, pending} + (PEND_W + 1)'(main_p0.burstcount);
  assign throttle  = main_p0.read && (pend_sum > (PEND_W + 1)'(MAX_PENDING));

  assign m0_read       = main_valid && main_p0.read && !throttle;
  assign m0_write      = main_valid && main_p0.write;
  assign m0_address    = main_p0.address;
  assign m0_writedata  = main_p0.writedata;
  assign m0_be         = main_p0.be;
  assign m0_burstcount = main_p0.burstcount;

  assign fire      = (m0_read || m0_write) && !m0_waitrequest;
  assign read_fire = m0_read && !m0_waitrequest;
  assign main_free = !main_valid || fire;

  assign s0_waitrequest = skid_valid;
  assign accept         = (s0_read || s0_write) && !skid_valid;

  // Command stage: main drives m0, skid catches the one command accepted while main stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_p0    <= '0;
      skid_p0    <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (main_free) begin
        main_p0    <= skid_p0;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end
    end else if (accept) begin
      if (main_free) begin
        main_p0    <= s0_cmd;
        main_valid <= 1'b1;
      end else begin
        skid_p0    <= s0_cmd;
        skid_valid <= 1'b1;
      end
    end else if (fire) begin
      main_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pending_next(pending, read_fire, main_p0.burstcount, m0_readdatavalid);
    end
  end

  // Response stages: plain delay line, no backpressure.
  generate
    if (RSP_STAGES == 0) begin : g_rsp_comb
      assign s0_readdata      = m0_readdata;
      assign s0_readdatavalid = m0_readdatavalid;
    end else begin : g_rsp_reg
      logic [DATA_WIDTH-1:0] rsp_data_p [RSP_STAGES];
      logic                  rsp_vld_p  [RSP_STAGES];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < RSP_STAGES; i++) begin
            rsp_data_p[i] <= '0;
            rsp_vld_p[i]  <= 1'b0;
          end
        end else begin
          rsp_data_p[0] <= m0_readdata;
          rsp_vld_p[0]  <= m0_readdatavalid;
          for (int i = 1; i < RSP_STAGES; i++) begin
            rsp_data_p[i] <= rsp_data_p[i-1];
            rsp_vld_p[i]  <= rsp_vld_p[i-1];
          end
        end
      end

      assign s0_readdata      = rsp_data_p[RSP_STAGES-1];
      assign s0_readdatavalid = rsp_vld_p[RSP_STAGES-1];
    end
  endgenerate

  a_rw_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(s0_read && s0_write));

  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    (m0_readdatavalid && !read_fire) |-> (pending != '0));

endmodule

// File: tb/tb_avl_skid_slicer.sv
// Directed bench for avl_skid_slicer with hand-computed expectations (default parameters).
module tb_avl_skid_slicer;

  localparam int AW  = 27;
  localparam int DW  = 576;
  localparam int BW  = 7;
  localparam int BEW = DW / 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [AW-1:0]  s0_address;
  logic           s0_read;
  logic           s0_write;
  logic [DW-1:0]  s0_writedata;
  logic [BEW-1:0] s0_be;
  logic [BW-1:0]  s0_burstcount;
  logic           s0_waitrequest;
  logic [DW-1:0]  s0_readdata;
  logic           s0_readdatavalid;
  logic [AW-1:0]  m0_address;
  logic           m0_read;
  logic           m0_write;
  logic [DW-1:0]  m0_writedata;
  logic [BEW-1:0] m0_be;
  logic [BW-1:0]  m0_burstcount;
  logic           m0_waitrequest;
  logic [DW-1:0]  m0_readdata;
  logic           m0_readdatavalid;

  int nvec = 0;
  int nerr = 0;

  avl_skid_slicer dut (
    .clk              (clk),
    .reset            (reset),
    .s0_address       (s0_address),
    .s0_read          (s0_read),
    .s0_write         (s0_write),
    .s0_writedata     (s0_writedata),
    .s0_be            (s0_be),
    .s0_burstcount    (s0_burstcount),
    .s0_waitrequest   (s0_waitrequest),
    .s0_readdata      (s0_readdata),
    .s0_readdatavalid (s0_readdatavalid),
    .m0_address       (m0_address),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_be            (m0_be),
    .m0_burstcount    (m0_burstcount),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    m0_readdatavalid = 1'b1;
    repeat (n) step();
    m0_readdatavalid = 1'b0;
  endtask

  task automatic cmd(input logic rd, input logic [AW-1:0] a, input logic [BW-1:0] bc);
    s0_read       = rd;
    s0_write      = !rd;
    s0_address    = a;
    s0_burstcount = bc;
  endtask

  logic [AW-1:0] got_q[$];
  int            idx;
  logic          acc;

  initial begin
    reset = 1'b1;
    s0_address = '0; s0_read = 1'b0; s0_write = 1'b0;
    s0_writedata = '0; s0_be = '0; s0_burstcount = '0;
    m0_waitrequest = 1'b0; m0_readdata = '0; m0_readdatavalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wait",  64'(s0_waitrequest), 0);
    chk("rst_m0rd",  64'(m0_read), 0);
    chk("rst_m0wr",  64'(m0_write), 0);
    chk("rst_addr",  64'(m0_address), 0);
    chk("rst_rdv",   64'(s0_readdatavalid), 0);
    chk("rst_pend",  64'(dut.pending), 0);
    reset = 1'b0;
    step();

    // Single read burst 4
    cmd(1'b1, 27'h100, 7'd4);
    step();
    s0_read = 1'b0;
    chk("rd_m0rd",  64'(m0_read), 1);
    chk("rd_addr",  64'(m0_address), 64'h100);
    chk("rd_bc",    64'(m0_burstcount), 4);
    step();
    chk("rd_pend4", 64'(dut.pending), 4);
    chk("rd_idle",  64'(m0_read), 0);
    for (int i = 0; i < 4; i++) begin
      m0_readdatavalid = 1'b1;
      m0_readdata      = '0;
      m0_readdata[63:0] = 64'hA0 + 64'(i);
      step();
      chk("rsp_vld",  64'(s0_readdatavalid), 1);
      chk("rsp_data", s0_readdata[63:0], 64'hA0 + 64'(i));
    end
    m0_readdatavalid = 1'b0;
    step();
    chk("rsp_end",  64'(s0_readdatavalid), 0);
    chk("rd_pend0", 64'(dut.pending), 0);

    // Back-to-back writes
    for (int i = 0; i < 8; i++) begin
      cmd(1'b0, AW'(i), 7'd1);
      s0_writedata = '0;
      s0_writedata[63:0] = 64'h5500 + 64'(i);
      s0_be = '1;
      step();
      chk("wr_wait", 64'(s0_waitrequest), 0);
      chk("wr_m0wr", 64'(m0_write), 1);
      chk("wr_addr", 64'(m0_address), 64'(i));
      chk("wr_data", m0_writedata[63:0], 64'h5500 + 64'(i));
    end
    s0_write = 1'b0;
    chk("wr_be", 64'(m0_be[7:0]), 64'hFF);
    step();
    chk("wr_idle", 64'(m0_write), 0);

    // Streaming writes with a 5-cycle downstream stall
    m0_waitrequest = 1'b1;
    idx = 0;
    got_q.delete();
    for (int c = 0; c < 20; c++) begin
      if (c == 2) chk("stall_wr_early", 64'(s0_waitrequest), 1);
      if (c == 5) begin
        chk("stall_absorb", 64'(idx), 2);
        chk("stall_wr", 64'(s0_waitrequest), 1);
        m0_waitrequest = 1'b0;
      end
      s0_write   = (idx < 6);
      s0_read    = 1'b0;
      s0_address = AW'(32'h10 + 32'(idx));
      acc = s0_write && !s0_waitrequest;
      if (m0_write && !m0_waitrequest) got_q.push_back(m0_address);
      step();
      if (acc) idx++;
    end
    s0_write = 1'b0;
    chk("stall_count", 64'(got_q.size()), 6);
    for (int i = 0; i < 6; i++)
      chk("stall_order", (i < got_q.size()) ? 64'(got_q[i]) : 64'hDEAD, 64'h10 + 64'(i));

    // Read throttling at MAX_PENDING
    cmd(1'b1, 27'h200, 7'd64);
    step();
    cmd(1'b1, 27'h240, 7'd64);
    step();
    cmd(1'b1, 27'h280, 7'd1);
    step();
    s0_read = 1'b0;
    chk("thr_pend128", 64'(dut.pending), 128);
    chk("thr_held",    64'(m0_read), 0);
    chk("thr_addr",    64'(m0_address), 64'h280);
    step();
    step();
    chk("thr_still",   64'(m0_read), 0);
    drain(1);
    chk("thr_release", 64'(m0_read), 1);
    step();
    chk("thr_refill",  64'(dut.pending), 128);
    drain(128);
    chk("thr_pend0",   64'(dut.pending), 0);

    // Read fire coinciding with a returned beat
    cmd(1'b1, 27'h0300, 7'd10);
    step();
    s0_read = 1'b0;
    step();
    chk("sim_pend10", 64'(dut.pending), 10);
    cmd(1'b1, 27'h0340, 7'd8);
    step();
    s0_read = 1'b0;
    chk("sim_m0rd", 64'(m0_read), 1);
    m0_readdatavalid = 1'b1;
    step();
    m0_readdatavalid = 1'b0;
    chk("sim_pend17", 64'(dut.pending), 17);
    drain(17);
    step();

    // Async reset with skid full and 30 beats outstanding
    cmd(1'b1, 27'h0380, 7'd31);
    step();
    s0_read = 1'b0;
    step();
    m0_waitrequest = 1'b1;
    cmd(1'b0, 27'h400, 7'd2);
    step();
    cmd(1'b0, 27'h401, 7'd2);
    m0_readdatavalid = 1'b1;
    step();
    s0_write = 1'b0;
    m0_readdatavalid = 1'b0;
    chk("pre_wait", 64'(s0_waitrequest), 1);
    chk("pre_pend", 64'(dut.pending), 30);
    chk("pre_rdv",  64'(s0_readdatavalid), 1);
    #3;
    reset = 1'b1;
    #1;
    chk("ar_wait", 64'(s0_waitrequest), 0);
    chk("ar_m0wr", 64'(m0_write), 0);
    chk("ar_m0rd", 64'(m0_read), 0);
    chk("ar_addr", 64'(m0_address), 0);
    chk("ar_bc",   64'(m0_burstcount), 0);
    chk("ar_rdv",  64'(s0_readdatavalid), 0);
    chk("ar_pend", 64'(dut.pending), 0);
    m0_waitrequest = 1'b0;
    step();
    reset = 1'b0;
    step();
    cmd(1'b1, 27'h500, 7'd2);
    step();
    s0_read = 1'b0;
    chk("post_m0rd", 64'(m0_read), 1);
    chk("post_addr", 64'(m0_address), 64'h500);
    step();
    chk("post_pend2", 64'(dut.pending), 2);
    drain(2);
    chk("post_pend0", 64'(dut.pending), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
